// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the MIPS controller and mul_div_unit.
// The o_div0 flag is present only when MDU_DIV0_FLAG_EN is defined.
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_rs;
    logic [WIDTH-1:0] i_rt;
    logic             i_mthi;
    logic             i_mtlo;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;
`ifdef MDU_DIV0_FLAG_EN
    logic             o_div0;
`endif

    modport master (
        output i_start, i_op, i_rs, i_rt, i_mthi, i_mtlo,
        input  o_busy, o_done, o_hi, o_lo
`ifdef MDU_DIV0_FLAG_EN
        , input o_div0
`endif
    );

    modport slave (
        input  i_start, i_op, i_rs, i_rt, i_mthi, i_mtlo,
        output o_busy, o_done, o_hi, o_lo
`ifdef MDU_DIV0_FLAG_EN
        , output o_div0
`endif
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO moves.
// Optional divide-by-zero flag output enabled by MDU_DIV0_FLAG_EN.
//
// state | meaning
// IDLE  | HI/LO stable, accepts start or MTHI/MTLO
// BUSY  | one shift-add / restoring-divide iteration per edge
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
`ifdef MDU_DIV0_FLAG_EN
    logic             div0_q, div0_d;
`endif

    logic             sgn_op;
    logic [WIDTH-1:0] rs_mag, rt_mag;
    logic [WIDTH:0]   mul_sum, div_rem, div_diff, acc_it;
    logic [WIDTH-1:0] sh_it, rem_mag;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    always_comb begin
        sgn_op = ~bus.i_op[0];
        rs_mag = (sgn_op && bus.i_rs[WIDTH-1]) ? -bus.i_rs : bus.i_rs;
        rt_mag = (sgn_op && bus.i_rt[WIDTH-1]) ? -bus.i_rt : bus.i_rt;
    end

    // Multiply: acc:sh is the product shifting right; divide: acc is the
    // partial remainder and sh shifts dividend bits out / quotient bits in.
    always_comb begin
        mul_sum  = acc_q + {1'b0, (sh_q[0] ? b_q : {WIDTH{1'b0}})};
        div_rem  = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, b_q};
        if (is_div_q) begin
            if (div_rem >= {1'b0, b_q}) begin
                acc_it = div_diff;
                sh_it  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_it = div_rem;
                sh_it  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_it = {1'b0, mul_sum[WIDTH:1]};
            sh_it  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod    = {acc_it[WIDTH-1:0], sh_it};
        prod_s  = neg_q_q ? -prod : prod;
        rem_mag = acc_it[WIDTH-1:0];
        if (!is_div_q) begin
            fin_hi = prod_s[2*WIDTH-1:WIDTH];
            fin_lo = prod_s[WIDTH-1:0];
        end else if (b_q == '0) begin
            fin_hi = rs_q;
            fin_lo = '1;
        end else begin
            fin_hi = neg_r_q ? -rem_mag : rem_mag;
            fin_lo = neg_q_q ? -sh_it : sh_it;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        b_d      = b_q;
        rs_d     = rs_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
        div0_d   = div0_q;
`endif
        if (state_q == IDLE) begin
            if (bus.i_start) begin
                state_d  = BUSY;
                cnt_d    = '0;
                is_div_d = bus.i_op[1];
                neg_q_d  = sgn_op & (bus.i_rs[WIDTH-1] ^ bus.i_rt[WIDTH-1]);
                neg_r_d  = sgn_op & bus.i_rs[WIDTH-1];
                acc_d    = '0;
                sh_d     = rs_mag;
                b_d      = rt_mag;
                rs_d     = bus.i_rs;
`ifdef MDU_DIV0_FLAG_EN
                div0_d   = 1'b0;
`endif
            end else if (bus.i_mthi || bus.i_mtlo) begin
                if (bus.i_mthi) hi_d = bus.i_rs;
                if (bus.i_mtlo) lo_d = bus.i_rs;
`ifdef MDU_DIV0_FLAG_EN
                div0_d = 1'b0;
`endif
            end
        end else begin
            acc_d = acc_it;
            sh_d  = sh_it;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = fin_hi;
                lo_d    = fin_lo;
`ifdef MDU_DIV0_FLAG_EN
                div0_d  = is_div_q & (b_q == '0);
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            acc_q    <= '0;
            sh_q     <= '0;
            b_q      <= '0;
            rs_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            b_q      <= b_d;
            rs_q     <= rs_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= div0_d;
`endif
        end
    end

    assign bus.o_busy = (state_q == BUSY);
    assign bus.o_done = done_q;
    assign bus.o_hi   = hi_q;
    assign bus.o_lo   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
    assign bus.o_div0 = div0_q;
`endif
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized ops
// compared against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] m_hi, m_lo;

    mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        p  = '0;
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'd2: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = q;
                    lo = p[31:0];
                    p = r;
                    hi = p[31:0];
                end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin hi = a % b; lo = a / b; end
            end
        endcase
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input bit hold, input bit mt);
        logic [31:0] e_hi, e_lo;
        int n;
        model(op, rs, rt, e_hi, e_lo);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_rs    = rs;
        bus.i_rt    = rt;
        bus.i_mtlo  = mt;
        bus.i_mthi  = 1'b0;
        @(posedge clk); #1;
        chk("busy_accept", 32'(bus.o_busy), 32'd1);
`ifdef MDU_DIV0_FLAG_EN
        chk("div0_clear", 32'(bus.o_div0), 32'd0);
`endif
        @(negedge clk);
        bus.i_start = hold;
        bus.i_op    = 2'($urandom);
        bus.i_rs    = $urandom;
        bus.i_rt    = $urandom;
        bus.i_mthi  = mt;
        n = 0;
        while (n < 40 && !bus.o_done) begin
            @(posedge clk); #1;
            n++;
            if (n == 16) begin
                chk("hold_hi", bus.o_hi, m_hi);
                chk("hold_lo", bus.o_lo, m_lo);
            end
        end
        chk("latency", 32'(n), 32'd32);
        chk("res_hi", bus.o_hi, e_hi);
        chk("res_lo", bus.o_lo, e_lo);
        chk("busy_done", 32'(bus.o_busy), 32'd0);
`ifdef MDU_DIV0_FLAG_EN
        chk("div0_flag", 32'(bus.o_div0), 32'((op[1] && rt == 0) ? 1 : 0));
`endif
        m_hi = e_hi;
        m_lo = e_lo;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_mthi  = 1'b0;
        bus.i_mtlo  = 1'b0;
        @(posedge clk); #1;
        chk("done_pulse", 32'(bus.o_done), 32'd0);
        chk("no_restart", 32'(bus.o_busy), 32'd0);
    endtask

    task automatic do_move(input bit hi, input bit lo, input logic [31:0] val);
        @(negedge clk);
        bus.i_mthi = hi;
        bus.i_mtlo = lo;
        bus.i_rs   = val;
        @(posedge clk); #1;
        if (hi) m_hi = val;
        if (lo) m_lo = val;
        chk("mv_hi", bus.o_hi, m_hi);
        chk("mv_lo", bus.o_lo, m_lo);
        chk("mv_done", 32'(bus.o_done), 32'd0);
        chk("mv_busy", 32'(bus.o_busy), 32'd0);
`ifdef MDU_DIV0_FLAG_EN
        chk("mv_div0", 32'(bus.o_div0), 32'd0);
`endif
        @(negedge clk);
        bus.i_mthi = 1'b0;
        bus.i_mtlo = 1'b0;
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        bus.i_op    = 2'd0;
        bus.i_rs    = '0;
        bus.i_rt    = '0;
        bus.i_mthi  = 1'b0;
        bus.i_mtlo  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #12;
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_hi", bus.o_hi, 32'd0);
        chk("rst_lo", bus.o_lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        do_move(1'b1, 1'b0, 32'h1234_5678);
        do_op(2'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, 1'b1);
        do_move(1'b1, 1'b1, 32'hCAFE_F00D);
        do_move(1'b0, 1'b1, 32'h0BAD_BEEF);
        do_op(2'd2, 32'd0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: a = $urandom_range(0, 50);
                1: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 9);
                default: b = $urandom;
            endcase
            do_op(op, a, b, 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_op    = 2'd3;
        bus.i_rs    = 32'd1000;
        bus.i_rt    = 32'd3;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.o_busy), 32'd0);
        chk("arst_hi", bus.o_hi, 32'd0);
        chk("arst_lo", bus.o_lo, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_done", 32'(bus.o_done), 32'd0);
        do_op(2'd3, 32'd1000, 32'd3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
